cba16_wide_add_sequencer: RTL and testbench
===========================================

// Module: cba16_wide_add_sequencer
// PURPOSE
//  Multi-cycle controller that runs one shared 16-bit carry-bypass adder
//  (carry_bypass_adder16) over WORDS slices, least significant slice first,
//  to produce a WORDS*16-bit add or subtract. Carry-out is fed back as the
//  next carry-in. Sits between a valid/ready operand producer and a
//  valid/ready result consumer. The adder is instantiated outside this block
//  and driven through the add_* ports.
// PARAMETERS
//  WORDS  4   number of 16-bit slices per operation; legal range 2..16
//  IDXW   4   index counter width; must satisfy 2**IDXW >= WORDS
// PORTS
//  clk        in   1         single clock, rising edge
//  rst_n      in   1         reset, asynchronous, active-low
//  in_valid   in   1         operand request
//  in_ready   out  1         block can accept operands
//  in_a       in   WORDS*16  operand A
//  in_b       in   WORDS*16  operand B
//  in_cin     in   1         carry-in; ignored when in_sub=1
//  in_sub     in   1         1: compute A-B; 0: compute A+B+cin
//  out_valid  out  1         result available
//  out_ready  in   1         consumer accepts the result
//  out_sum    out  WORDS*16  result
//  out_cout   out  1         final carry; for subtract, 1 = no borrow
//  busy       out  1         high in RUN or DONE
//  add_a      out  16        to adder a
//  add_b      out  16        to adder b
//  add_cin    out  1         to adder cin
//  add_sum    in   16        from adder sum (combinational path)
//  add_cout   in   1         from adder cout (combinational path)
// BEHAVIOUR
//  States: IDLE, RUN, DONE.
//  Reset (rst_n=0, async): state=IDLE.
//   Output reset values: in_ready=1, out_valid=0, out_sum=0, out_cout=0,
//   busy=0, add_a=0, add_b=0, add_cin=0.
//   Internal registers: idx=0, carry=0, op_a=0, op_b=0.
//  IDLE:
//   - in_ready=1.
//   - On in_valid at a clock edge: latch op_a=in_a.
//   - op_b = in_sub ? ~in_b : in_b.
//   - carry = in_sub ? 1 : in_cin.
//   - idx=0; go to RUN.
//  RUN:
//   - in_ready=0.
//   - add_a = op_a[idx*16+:16]; add_b = op_b[idx*16+:16]; add_cin = carry.
//   - Each edge: out_sum[idx*16+:16] <= add_sum; carry <= add_cout;
//     idx <= idx+1.
//   - On the edge where idx==WORDS-1: out_cout <= add_cout; go to DONE.
//   - The RUN phase takes exactly WORDS cycles.
//  DONE:
//   - out_valid=1; out_sum and out_cout are held stable.
//   - On out_ready: go to IDLE and clear out_valid.
//   - out_sum keeps its value until the next operation overwrites it.
//  Outside RUN, add_a, add_b and add_cin are driven to 0.
//  Latency: operands accepted at edge k; out_valid=1 in the cycle after edge
//   k+WORDS. One operation is in flight at a time. Throughput is one result
//   per WORDS+2 cycles when out_ready is held high.
//  in_valid outside IDLE is ignored: it is not latched and causes no error.
//   The producer must hold its request until in_ready=1.
//  The input and output handshakes cannot complete in the same cycle:
//   in_ready=1 only in IDLE, out_valid=1 only in DONE.
//  Reset asserted during RUN or DONE aborts the operation immediately.
//   No partial result is ever presented.
//  Width rule: the result is modulo 2**(16*WORDS); overflow is reported only
//   through out_cout.
// TESTING (WORDS=4)
//  1 Add 0xFFFF_FFFF_FFFF_FFFF + 0x1, cin=0 -> out_sum=0, out_cout=1;
//    out_valid in the 5th cycle after accept.
//  2 Cross-slice carry: 0x0000_0000_0000_FFFF + 0x1 -> out_sum=0x0001_0000,
//    out_cout=0; check add_cin=1 in the second RUN cycle.
//  3 Subtract 0x5 - 0x7, in_sub=1, in_cin=1 (ignored) ->
//    out_sum=0xFFFF_FFFF_FFFF_FFFE, out_cout=0.
//  4 Backpressure: hold out_ready=0 for 3 cycles in DONE -> out_valid and
//    out_sum stable, in_ready=0; a new in_valid in that window is not
//    accepted.
//  5 Drop rst_n in the 2nd RUN cycle -> outputs immediately take their reset
//    values. Then a new add 0x1234 + 0x1 -> 0x1235, with no stale upper slices.
//  6 Back-to-back operations, out_ready=1, in_valid=1 continuously ->
//    one accept every 6 cycles, results in order.

Source files
------------

// File: rtl/cba16_wide_add_sequencer_if.sv
// cba16_wide_add_sequencer_if: operand/result valid-ready bus (master drives operands, slave returns the result)
interface cba16_wide_add_sequencer_if #(parameter int WORDS = 4);
  logic                  in_valid;
  logic                  in_ready;
  logic [WORDS*16-1:0]   in_a;
  logic [WORDS*16-1:0]   in_b;
  logic                  in_cin;
  logic                  in_sub;
  logic                  out_valid;
  logic                  out_ready;
  logic [WORDS*16-1:0]   out_sum;
  logic                  out_cout;
  modport master (output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
                  input in_ready, out_valid, out_sum, out_cout);
  modport slave (input in_valid, in_a, in_b, in_cin, in_sub, out_ready,
                 output in_ready, out_valid, out_sum, out_cout);
endinterface

// File: rtl/cba16_wide_add_sequencer.sv
// cba16_wide_add_sequencer: WORDS*16-bit add/sub over one external 16-bit adder (ports: clk, rst_n, bus slave, busy, add_a/b/cin out, add_sum/cout in)
module cba16_wide_add_sequencer #(
  parameter int WORDS = 4,
  parameter int IDXW  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  cba16_wide_add_sequencer_if.slave    bus,
  output logic                         busy,
  output logic [15:0]                  add_a,
  output logic [15:0]                  add_b,
  output logic                         add_cin,
  input  logic [15:0]                  add_sum,
  input  logic                         add_cout
);
  localparam int N = WORDS * 16;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t          state_q;
  logic [IDXW-1:0] idx_q;
  logic            carry_q;
  logic            cout_q;
  logic [N-1:0]    op_a_q;
  logic [N-1:0]    op_b_q;
  logic [N-1:0]    sum_q;
  logic            run;
  assign run           = state_q == RUN;
  assign bus.in_ready  = state_q == IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;
  assign busy          = state_q != IDLE;
  assign add_a         = run ? op_a_q[idx_q*16 +: 16] : '0;
  assign add_b         = run ? op_b_q[idx_q*16 +: 16] : '0;
  assign add_cin       = run & carry_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          op_a_q  <= bus.in_a;
          op_b_q  <= bus.in_sub ? ~bus.in_b : bus.in_b;
          carry_q <= bus.in_sub | bus.in_cin;
          idx_q   <= '0;
          state_q <= RUN;
        end
        RUN: begin
          sum_q[idx_q*16 +: 16] <= add_sum;
          carry_q               <= add_cout;
          idx_q                 <= idx_q + 1'b1;
          if (idx_q == IDXW'(WORDS - 1)) begin
            cout_q  <= add_cout;
            state_q <= DONE;
          end
        end
        DONE: if (bus.out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cba16_wide_add_sequencer.sv
// tb_cba16_wide_add_sequencer: randomized self-checking bench against an arithmetic reference model
module tb_cba16_wide_add_sequencer;
  localparam int W = 4;
  localparam int N = W * 16;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          busy;
  logic [15:0]   add_a, add_b, add_sum;
  logic          add_cin, add_cout;
  int            checks = 0;
  int            errors = 0;
  logic          cins [W];
  cba16_wide_add_sequencer_if #(.WORDS(W)) bus ();
  cba16_wide_add_sequencer #(.WORDS(W), .IDXW(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + 17'(add_cin);
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [N:0] got, input logic [N:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask
  function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin, input logic sub);
    return sub ? {a >= b, N'(a - b)} : (N+1)'(a) + (N+1)'(b) + (N+1)'(cin);
  endfunction
  task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin, input logic sub, output int lat);
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_cin = cin; bus.in_sub = sub;
    chk("ready_before_accept", N'(bus.in_ready), 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("busy_after_accept", {bus.in_ready, busy}, 1);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      if (lat < W) cins[lat] = add_cin;
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", N'(lat), W);
  endtask
  task automatic finish_op;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("idle_after_take", {bus.out_valid, bus.in_ready, busy}, 3'b010);
  endtask
  task automatic full_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b, input logic cin, input logic sub);
    int lat;
    start_op(a, b, cin, sub, lat);
    chk(tag, {bus.out_cout, bus.out_sum}, model(a, b, cin, sub));
    finish_op();
  endtask
  initial begin
    int lat;
    logic [N:0] snap;
    logic [N-1:0] qa [$];
    logic [N-1:0] qb [$];
    logic [N:0] exp_q [$];
    int acc_t [$];
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_cin = 1'b0; bus.in_sub = 1'b0;
    bus.out_ready = 1'b0;
    #2;
    chk("reset_outputs", {bus.in_ready, bus.out_valid, busy, add_cin, bus.out_cout}, 5'b10000);
    chk("reset_sum", {1'b0, bus.out_sum}, 0);
    chk("reset_add", {add_a, add_b}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    start_op({N{1'b1}}, N'(1), 1'b0, 1'b0, lat);
    chk("t1_wrap", {bus.out_cout, bus.out_sum}, {1'b1, N'(0)});
    finish_op();
    start_op(N'(16'hFFFF), N'(1), 1'b0, 1'b0, lat);
    chk("t2_cross", {bus.out_cout, bus.out_sum}, {1'b0, N'(32'h0001_0000)});
    chk("t2_cin_run1", N'(cins[1]), 1);
    chk("t2_cin_run0", N'(cins[0]), 0);
    finish_op();
    full_op("t3_sub", N'(5), N'(7), 1'b1, 1'b1);
    chk("t3_model_const", model(N'(5), N'(7), 1'b1, 1'b1), {1'b0, {(N-1){1'b1}}, 1'b0});
    start_op(N'(64'h0123_4567_89AB_CDEF), N'(64'h1111_2222_3333_4444), 1'b1, 1'b0, lat);
    snap = {bus.out_cout, bus.out_sum};
    chk("t4_result", snap, model(N'(64'h0123_4567_89AB_CDEF), N'(64'h1111_2222_3333_4444), 1'b1, 1'b0));
    bus.in_valid = 1'b1; bus.in_a = N'(99); bus.in_b = N'(1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("t4_hold", {bus.out_valid, bus.in_ready, bus.out_cout, bus.out_sum}, {2'b10, snap});
    end
    bus.in_valid = 1'b0;
    finish_op();
    @(posedge clk); #1;
    chk("t4_no_accept", N'(busy), 0);
    bus.in_valid = 1'b1; bus.in_a = {N{1'b1}}; bus.in_b = {N{1'b1}}; bus.in_cin = 1'b0; bus.in_sub = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("t5_abort_ctl", {bus.in_ready, bus.out_valid, busy, add_cin, bus.out_cout}, 5'b10000);
    chk("t5_abort_sum", {1'b0, bus.out_sum}, 0);
    chk("t5_abort_add", {add_a, add_b}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    full_op("t5_after", N'(16'h1234), N'(1), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      logic [N-1:0] a, b;
      a = {$urandom, $urandom};
      b = (i % 5 == 0) ? a : {$urandom, $urandom};
      full_op("rand_op", a, b, 1'($urandom), 1'($urandom));
    end
    for (int i = 0; i < 6; i++) begin
      logic [N-1:0] a, b;
      logic c, s;
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = 1'($urandom); s = 1'($urandom);
      qa.push_back(a); qb.push_back(b);
      exp_q.push_back(model(a, b, c, s));
      exp_q[i] = model(a, b, c, s);
    end
    begin
      int n = 0;
      int got = 0;
      int cyc = 0;
      bit acc, take;
      logic [N-1:0] ca, cb;
      ca = qa[0]; cb = qb[0];
      bus.out_ready = 1'b1;
      while (got < 6 && cyc < 200) begin
        if (n < 6) begin
          bus.in_valid = 1'b1; bus.in_a = qa[n]; bus.in_b = qb[n];
        end else bus.in_valid = 1'b0;
        bus.in_cin = 1'b0; bus.in_sub = 1'b0;
        acc = bus.in_valid && bus.in_ready;
        take = bus.out_valid && bus.out_ready;
        if (take) begin
          chk("t6_order", {bus.out_cout, bus.out_sum}, model(qa[got], qb[got], 1'b0, 1'b0));
          got++;
        end
        @(posedge clk); #1;
        cyc++;
        if (acc) begin
          acc_t.push_back(cyc);
          n++;
        end
      end
      chk("t6_all_results", N'(got), 6);
      for (int i = 1; i < acc_t.size(); i++) chk("t6_spacing", N'(acc_t[i] - acc_t[i-1]), W + 2);
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
